apb_reg_completer: RTL and testbench

APB_REG_COMPLETER -- requirements
Module: apb_reg_completer

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_regfile.sv | 86 ++++++++
 rtl/apb_reg_completer.sv | 126 ++++++++++++
 tb/tb_apb_reg_completer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions used by the register completer and the bridge.
//   NUM_REGS / NUM_SCRATCH : size of the decoded register window
//   ADDR_*                 : fixed register addresses
//   apb_state_t            : completer handshake states
//   addr_is_ro()           : true for the read-only register addresses
package apb_pkg;

   localparam int NUM_REGS    = 16;
   localparam int NUM_SCRATCH = 12;

   localparam logic [7:0] ADDR_ID   = 8'h0C;
   localparam logic [7:0] ADDR_CNT  = 8'h0D;
   localparam logic [7:0] ADDR_XFER = 8'h0E;
   localparam logic [7:0] ADDR_CTRL = 8'h0F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } apb_state_t;

   function automatic logic addr_is_ro(input logic [7:0] addr);
      return (addr >= ADDR_ID) && (addr <= ADDR_XFER);
   endfunction

endpackage

// File: rtl/apb_regfile.sv
// Register array and address decode for the APB completer.
//   clk, rst     : clock, async active-high reset
//   addr, write  : current APB address / direction (decode is combinational)
//   wdata        : write data
//   commit       : transfer completes at the next rising edge
//   rdata        : read data for addr (0 when the access errors)
//   err          : access would complete with an error
//   ctrl         : live CTRL register value
module apb_regfile
   import apb_pkg::*;
#(
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] addr,
   input  logic       write,
   input  logic [7:0] wdata,
   input  logic       commit,
   output logic [7:0] rdata,
   output logic       err,
   output logic [7:0] ctrl
);

   logic [7:0] scratch [NUM_SCRATCH];
   logic [7:0] cnt;
   logic [7:0] xfer;
   logic [7:0] ctrl_q;

   logic wr_ok;
   logic ctrl_we;
   logic scratch_we;
   logic in_scratch;

   assign in_scratch = addr < 8'(NUM_SCRATCH);
   assign err        = (addr >= 8'(NUM_REGS)) | (write & addr_is_ro(addr));
   assign wr_ok      = commit & write & ~err;
   assign ctrl_we    = wr_ok & (addr == ADDR_CTRL);
   assign scratch_we = wr_ok & in_scratch;
   assign ctrl       = ctrl_q;

   always_comb begin
      rdata = 8'h00;
      if (!err) begin
         if (in_scratch) begin
            rdata = scratch[addr[3:0]];
         end else begin
            unique case (addr)
               ADDR_ID:   rdata = ID_VALUE;
               ADDR_CNT:  rdata = cnt;
               ADDR_XFER: rdata = xfer;
               ADDR_CTRL: rdata = ctrl_q;
               default:   rdata = 8'h00;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= 8'h00;
      end else if (scratch_we) begin
         scratch[addr[3:0]] <= wdata;
      end
   end

   // A clear request in the committed CTRL value overrides this edge's increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      cnt <= 8'h00;
      else if (ctrl_we && wdata[1]) cnt <= 8'h00;
      else if (ctrl_q[0])           cnt <= cnt + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                xfer <= 8'h00;
      else if (commit && !err) xfer <= xfer + 8'd1;
   end

   // CTRL[1] is a one-cycle pulse: stored on commit, dropped the cycle after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            ctrl_q    <= 8'h00;
      else if (ctrl_we)   ctrl_q    <= wdata;
      else if (ctrl_q[1]) ctrl_q[1] <= 1'b0;
   end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer with configurable wait states in front of apb_regfile.
//   clk, rst                       : clock, async active-high reset
//   psel, penable, pwrite          : APB control
//   paddr, pwdata                  : APB address / write data
//   prdata, pready, pslverr        : registered APB response
//   ctrl_out                       : live CTRL register value
//
// state     | meaning
// ST_IDLE   | no transfer; waiting for a setup phase
// ST_ACCESS | setup seen; counting access cycles until pready
// ST_DONE   | transfer just completed; may accept a back-to-back setup
module apb_reg_completer
   import apb_pkg::*;
#(
   parameter int         WAIT_STATES = 0,
   parameter logic [7:0] ID_VALUE    = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   output logic [7:0] ctrl_out
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   apb_state_t state, state_nxt;
   logic [2:0] wait_cnt, wait_nxt;
   logic       pready_nxt, pslverr_nxt;
   logic       commit;
   logic       setup;
   logic       access;
   logic [7:0] rdata;
   logic       err;

   assign setup  = psel & ~penable;
   assign access = psel &  penable;

   apb_regfile #(.ID_VALUE(ID_VALUE)) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .addr   (paddr),
      .write  (pwrite),
      .wdata  (pwdata),
      .commit (commit),
      .rdata  (rdata),
      .err    (err),
      .ctrl   (ctrl_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= 3'd0;
         pready   <= 1'b0;
         pslverr  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         pready   <= pready_nxt;
         pslverr  <= pslverr_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  prdata <= 8'h00;
      else if (commit && !pwrite) prdata <= rdata;
   end

   // pready/pslverr are registered, so both are loaded one cycle ahead of the
   // access cycle in which they must be visible.
   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      pready_nxt  = pready;
      pslverr_nxt = pslverr;
      commit      = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            pready_nxt  = 1'b0;
            pslverr_nxt = 1'b0;
            state_nxt   = ST_IDLE;
            if (setup) begin
               state_nxt = ST_ACCESS;
               wait_nxt  = 3'd0;
               if (WS == 4'd0) begin
                  pready_nxt  = 1'b1;
                  pslverr_nxt = err;
               end
            end
         end
         ST_ACCESS: begin
            if (!psel) begin
               state_nxt   = ST_IDLE;
               pready_nxt  = 1'b0;
               pslverr_nxt = 1'b0;
            end else if (access) begin
               if (pready) begin
                  commit      = 1'b1;
                  state_nxt   = ST_DONE;
                  pready_nxt  = 1'b0;
                  pslverr_nxt = 1'b0;
               end else begin
                  wait_nxt = wait_cnt + 3'd1;
                  if (({1'b0, wait_cnt} + 4'd1) == WS) begin
                     pready_nxt  = 1'b1;
                     pslverr_nxt = err;
                  end
               end
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            pready_nxt  = 1'b0;
            pslverr_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_apb_reg_completer.sv
module tb_apb_reg_completer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst     [3];
   logic       psel    [3];
   logic       penable [3];
   logic       pwrite  [3];
   logic [7:0] paddr   [3];
   logic [7:0] pwdata  [3];
   logic [7:0] prdata  [3];
   logic       pready  [3];
   logic       pslverr [3];
   logic [7:0] ctrl_out[3];

   apb_reg_completer #(.WAIT_STATES(0), .ID_VALUE(8'hA5)) u_ws0 (
      .clk(clk), .rst(rst[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
      .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
      .pslverr(pslverr[0]), .ctrl_out(ctrl_out[0]));

   apb_reg_completer #(.WAIT_STATES(2), .ID_VALUE(8'h5A)) u_ws2 (
      .clk(clk), .rst(rst[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
      .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
      .pslverr(pslverr[1]), .ctrl_out(ctrl_out[1]));

   apb_reg_completer #(.WAIT_STATES(3), .ID_VALUE(8'hA5)) u_ws3 (
      .clk(clk), .rst(rst[2]), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
      .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]), .pready(pready[2]),
      .pslverr(pslverr[2]), .ctrl_out(ctrl_out[2]));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         id;
      bit         rd;
      bit         err;
      logic [7:0] rdata;
      bit         chk_ctrl;
      logic [7:0] ctrl;
   } exp_t;

   exp_t sb[$];

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h want %02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkint(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_scr  [3][12];
   logic [7:0] m_xfer [3];
   logic [7:0] m_ctrl [3];
   logic [7:0] m_cbase[3];
   int         m_ccyc [3];

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
   endfunction

   function automatic logic [7:0] id_of(input int k);
      return (k == 1) ? 8'h5A : 8'hA5;
   endfunction

   // CNT value during clock interval n (the interval after edge number n).
   function automatic logic [7:0] m_cnt(input int k, input int n);
      if (m_ctrl[k][0]) return 8'(int'(m_cbase[k]) + (n - m_ccyc[k]));
      return m_cbase[k];
   endfunction

   task automatic m_reset(input int k);
      for (int i = 0; i < 12; i++) m_scr[k][i] = 8'h00;
      m_xfer[k]  = 8'h00;
      m_ctrl[k]  = 8'h00;
      m_cbase[k] = 8'h00;
      m_ccyc[k]  = cyc;
   endtask

   // Full transfer; called at posedge+1, returns at posedge+1 with the bus idle.
   task automatic apb_xfer(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d);
      exp_t       e;
      int         c, n;
      bit         err;
      logic [7:0] rv;
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
      c   = cyc + ws_of(k) + 1;  // interval ending in the commit edge
      err = (a >= 8'h10) || (wr && a >= 8'h0C && a <= 8'h0E);
      rv  = 8'h00;
      if (!err && !wr) begin
         if (a < 8'd12) rv = m_scr[k][a];
         else case (a)
            8'h0C: rv = id_of(k);
            8'h0D: rv = m_cnt(k, c);
            8'h0E: rv = m_xfer[k];
            default: rv = m_ctrl[k];
         endcase
      end
      e.id = k; e.rd = !wr; e.err = err; e.rdata = rv; e.chk_ctrl = 1'b0; e.ctrl = 8'h00;
      if (!err) begin
         m_xfer[k] = m_xfer[k] + 8'd1;
         if (wr && a < 8'd12) m_scr[k][a] = d;
         if (wr && a == 8'h0F) begin
            m_cbase[k] = d[1] ? 8'h00 : 8'(m_cnt(k, c) + {7'b0, m_ctrl[k][0]});
            m_ccyc[k]  = c + 1;
            m_ctrl[k]  = d & 8'hFD;
            e.chk_ctrl = 1'b1;
            e.ctrl     = d;
         end
      end
      sb.push_back(e);
      @(posedge clk); #1;
      penable[k] = 1'b1;
      n = 1;
      @(negedge clk);
      while (!pready[k] && n < 20) begin
         @(posedge clk); #1;
         n++;
         @(negedge clk);
      end
      checkint("access_cycles_to_pready", n, ws_of(k) + 1);
      @(posedge clk); #1;
      psel[k] = 1'b0; penable[k] = 1'b0;
   endtask

   task automatic idle(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   // ---------------- monitor ----------------
   bit   pend[3];
   exp_t pe  [3];
   exp_t mon_e;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (pend[k]) begin
            if (pe[k].rd)       check8("prdata", prdata[k], pe[k].rdata);
            if (pe[k].chk_ctrl) check8("ctrl_out_after_write", ctrl_out[k], pe[k].ctrl);
            check8("pready_in_done", {7'b0, pready[k]}, 8'h00);
            pend[k] = 1'b0;
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (!rst[k] && psel[k] && penable[k] && pready[k]) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_completion: inst %0d completed with nothing expected", k);
            end else begin
               mon_e = sb.pop_front();
               checkint("completion_instance", k, mon_e.id);
               check8("pslverr", {7'b0, pslverr[k]}, {7'b0, mon_e.err});
               pend[k] = 1'b1;
               pe[k]   = mon_e;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
         paddr[k] = 8'h00; pwdata[k] = 8'h00; pend[k] = 1'b0;
      end
      @(posedge clk); @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         check8("reset_prdata",  prdata[k], 8'h00);
         check8("reset_pready",  {7'b0, pready[k]}, 8'h00);
         check8("reset_pslverr", {7'b0, pslverr[k]}, 8'h00);
         check8("reset_ctrl",    ctrl_out[k], 8'h00);
         rst[k] = 1'b0;
         m_reset(k);
      end
      idle(1);

      // basic write/read, zero wait states, then XFER
      apb_xfer(0, 1, 8'h05, 8'h3C);
      apb_xfer(0, 0, 8'h05, 8'h00);
      apb_xfer(0, 0, 8'h0E, 8'h00);

      // wait-state read of ID
      apb_xfer(2, 0, 8'h0C, 8'h00);

      // error cases
      apb_xfer(0, 1, 8'h0C, 8'h12);
      apb_xfer(0, 0, 8'h20, 8'h00);
      apb_xfer(0, 1, 8'h20, 8'h77);
      apb_xfer(0, 0, 8'h0C, 8'h00);
      apb_xfer(0, 0, 8'h0E, 8'h00);

      // free-running counter with wrap, then clear
      apb_xfer(0, 1, 8'h0F, 8'h01);
      idle(300);
      apb_xfer(0, 0, 8'h0D, 8'h00);
      apb_xfer(0, 1, 8'h0F, 8'h03);
      apb_xfer(0, 0, 8'h0D, 8'h00);
      apb_xfer(0, 0, 8'h0F, 8'h00);
      apb_xfer(0, 1, 8'h0F, 8'h00);

      // abort mid-access (WAIT_STATES=2)
      apb_xfer(1, 1, 8'h07, 8'h55);
      idle(1);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h07; pwdata[1] = 8'hAA;
      @(posedge clk); #1; penable[1] = 1'b1;
      @(posedge clk); #1; psel[1] = 1'b0; penable[1] = 1'b0;
      @(negedge clk); check8("abort_pready", {7'b0, pready[1]}, 8'h00);
      idle(1);
      apb_xfer(1, 0, 8'h07, 8'h00);
      apb_xfer(1, 0, 8'h0E, 8'h00);

      // penable without setup is ignored
      psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 8'h02; pwdata[1] = 8'hEE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); check8("no_setup_pready", {7'b0, pready[1]}, 8'h00);
      end
      @(posedge clk); #1; psel[1] = 1'b0; penable[1] = 1'b0;
      apb_xfer(1, 0, 8'h02, 8'h00);
      apb_xfer(1, 0, 8'h0C, 8'h00);

      // reset during a WAIT_STATES=3 write
      apb_xfer(2, 1, 8'h03, 8'h77);
      apb_xfer(2, 1, 8'h0F, 8'h04);
      apb_xfer(2, 0, 8'h03, 8'h00);
      idle(2);
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h03; pwdata[2] = 8'h99;
      @(posedge clk); #1; penable[2] = 1'b1;
      @(posedge clk); #2; rst[2] = 1'b1;
      #1;
      check8("rst_prdata",  prdata[2], 8'h00);
      check8("rst_pready",  {7'b0, pready[2]}, 8'h00);
      check8("rst_pslverr", {7'b0, pslverr[2]}, 8'h00);
      check8("rst_ctrl",    ctrl_out[2], 8'h00);
      psel[2] = 1'b0; penable[2] = 1'b0;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      m_reset(2);
      apb_xfer(2, 0, 8'h03, 8'h00);
      apb_xfer(2, 0, 8'h0F, 8'h00);
      apb_xfer(2, 0, 8'h0E, 8'h00);

      // randomized traffic on every instance
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 60; i++) begin
            logic [7:0] a;
            bit         w;
            if ($urandom_range(0, 9) == 0) a = 8'($urandom);
            else                           a = 8'($urandom_range(0, 15));
            w = 1'($urandom);
            apb_xfer(k, w, a, 8'($urandom));
            idle($urandom_range(0, 2));
         end
      end

      idle(4);
      checkint("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
